// File: rtl/gol_generation_sequencer.sv
// Game of Life generation sequencer: streams a three-row window from the read bank
// into an external datapath and writes the result rows to the opposite bank.
// Optional toroidal row wrap is enabled by defining GOL_TORUS_WRAP_EN.
module gol_generation_sequencer #(
  parameter int unsigned ROWS   = 32,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [15:0]       gen_count,
  output logic              rd_bank,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  row_top,
  output logic [WIDTH-1:0]  row_mid,
  output logic [WIDTH-1:0]  row_bot,
  input  logic [WIDTH-1:0]  update
);

`ifdef GOL_TORUS_WRAP_EN
  // Read the last row first and row 0 again at the end so the window wraps vertically.
  localparam int unsigned NUM_READS      = ROWS + 2;
  localparam int unsigned FIRST_RD       = ROWS - 1;
  localparam int unsigned FIRST_WR_SHIFT = 3;
  localparam bit          TORUS          = 1'b1;
`else
  localparam int unsigned NUM_READS      = ROWS;
  localparam int unsigned FIRST_RD       = 0;
  localparam int unsigned FIRST_WR_SHIFT = 2;
  localparam bit          TORUS          = 1'b0;
`endif
  localparam int unsigned CNT_W = $clog2(ROWS + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q;
  logic                busy_q;
  logic                done_q;
  logic [15:0]         gen_count_q;
  logic                rd_bank_q;
  logic                rd_en_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [CNT_W-1:0]    rd_cnt_q;
  logic                rd_vld_q;
  logic                zero_inj_q;
  logic [1:0]          shifts_q;
  logic                wr_arm_q;
  logic [ADDR_W-1:0]   wr_idx_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [WIDTH-1:0]    wr_data_q;
  logic [WIDTH-1:0]    top_q;
  logic [WIDTH-1:0]    mid_q;
  logic [WIDTH-1:0]    bot_q;

  logic                shift_c;
  logic [WIDTH-1:0]    incoming_c;
  logic                last_rd_c;
  logic                last_wr_c;
  logic [ADDR_W-1:0]   rd_addr_d;

  // A row enters the window when a read returns or the virtual dead row is injected.
  assign shift_c    = rd_vld_q | zero_inj_q;
  assign incoming_c = zero_inj_q ? '0 : rd_data;
  assign last_rd_c  = (rd_cnt_q == CNT_W'(NUM_READS - 1));
  assign last_wr_c  = wr_en_q && (wr_addr_q == ADDR_W'(ROWS - 1));
  assign rd_addr_d  = (rd_addr_q == ADDR_W'(ROWS - 1)) ? '0 : rd_addr_q + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      gen_count_q <= '0;
      rd_bank_q   <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_cnt_q    <= '0;
      rd_vld_q    <= 1'b0;
      zero_inj_q  <= 1'b0;
      shifts_q    <= '0;
      wr_arm_q    <= 1'b0;
      wr_idx_q    <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      top_q       <= '0;
      mid_q       <= '0;
      bot_q       <= '0;
    end else begin
      done_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_arm_q   <= 1'b0;
      zero_inj_q <= 1'b0;
      rd_vld_q   <= rd_en_q;

      if (shift_c) begin
        top_q <= mid_q;
        mid_q <= bot_q;
        bot_q <= incoming_c;
        if (shifts_q != 2'd3) begin
          shifts_q <= shifts_q + 2'd1;
        end
        // Once the middle slot holds a real row, its result is written next cycle.
        if (shifts_q >= 2'(FIRST_WR_SHIFT - 1)) begin
          wr_arm_q <= 1'b1;
        end
      end

      if (wr_arm_q) begin
        wr_en_q   <= 1'b1;
        wr_data_q <= update;
        wr_addr_q <= wr_idx_q;
        wr_idx_q  <= wr_idx_q + ADDR_W'(1);
      end

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_FETCH;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= ADDR_W'(FIRST_RD);
            rd_cnt_q  <= '0;
            shifts_q  <= '0;
            wr_idx_q  <= '0;
            top_q     <= '0;
            mid_q     <= '0;
            bot_q     <= '0;
          end
        end
        S_FETCH: begin
          if (last_rd_c) begin
            rd_en_q <= 1'b0;
            state_q <= TORUS ? S_DRAIN : S_FLUSH;
          end else begin
            rd_addr_q <= rd_addr_d;
            rd_cnt_q  <= rd_cnt_q + CNT_W'(1);
          end
        end
        S_FLUSH: begin
          zero_inj_q <= 1'b1;
          state_q    <= S_DRAIN;
        end
        S_DRAIN: begin
          if (last_wr_c) begin
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            rd_bank_q   <= ~rd_bank_q;
            gen_count_q <= gen_count_q + 16'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign gen_count = gen_count_q;
  assign rd_bank   = rd_bank_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign row_top   = top_q;
  assign row_mid   = mid_q;
  assign row_bot   = bot_q;

endmodule

// File: tb/tb_gol_generation_sequencer.sv
// Bench for gol_generation_sequencer: two-bank row memory, combinational Life datapath
// and a grid-level reference model of one generation (dead columns at the edges).
module tb_gol_generation_sequencer;
  localparam int unsigned ROWS   = 32;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned ADDR_W = 5;
`ifdef GOL_TORUS_WRAP_EN
  localparam bit TORUS      = 1'b1;
  localparam int NUM_READS  = ROWS + 2;
  localparam int FIRST_WR_C = 6;
`else
  localparam bit TORUS      = 1'b0;
  localparam int NUM_READS  = ROWS;
  localparam int FIRST_WR_C = 5;
`endif
  localparam int DONE_C = FIRST_WR_C + ROWS;

  logic              clk;
  logic              reset;
  logic              start;
  logic              busy;
  logic              done;
  logic [15:0]       gen_count;
  logic              rd_bank;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [WIDTH-1:0]  row_top;
  logic [WIDTH-1:0]  row_mid;
  logic [WIDTH-1:0]  row_bot;
  logic [WIDTH-1:0]  update;

  logic [WIDTH-1:0]  mem [2][ROWS];
  logic [WIDTH-1:0]  cur_grid [ROWS];
  logic [WIDTH-1:0]  exp_next [ROWS];
  bit                exp_bank;
  logic [15:0]       exp_gen;
  int                checks;
  int                failures;

  gol_generation_sequencer #(.ROWS(ROWS), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .gen_count(gen_count), .rd_bank(rd_bank), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .row_top(row_top), .row_mid(row_mid), .row_bot(row_bot), .update(update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational datapath: next state of the middle row, dead cells beyond the edges.
  function automatic logic [WIDTH-1:0] dp_next(input logic [WIDTH-1:0] t,
                                               input logic [WIDTH-1:0] m,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int j = 0; j < int'(WIDTH); j++) begin
      int n;
      n = 0;
      for (int k = -1; k <= 1; k++) begin
        int idx;
        idx = j + k;
        if (idx >= 0 && idx < int'(WIDTH)) begin
          if (t[idx]) n++;
          if (b[idx]) n++;
          if (k != 0 && m[idx]) n++;
        end
      end
      r[j] = (n == 3) || (m[j] && n == 2);
    end
    return r;
  endfunction

  assign update = dp_next(row_top, row_mid, row_bot);

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_bank][rd_addr];
  end

  always @(posedge clk) begin
    if (wr_en) mem[~rd_bank][wr_addr] = wr_data;
  end

  // Reference: whole-grid neighbour count per cell.
  task automatic compute_next();
    for (int r = 0; r < int'(ROWS); r++) begin
      for (int c = 0; c < int'(WIDTH); c++) begin
        int n;
        logic [WIDTH-1:0] rowv;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr;
            int cc;
            rr = r + dr;
            cc = c + dc;
            if (TORUS) rr = (rr + int'(ROWS)) % int'(ROWS);
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < int'(ROWS) &&
                cc >= 0 && cc < int'(WIDTH)) begin
              rowv = cur_grid[rr];
              if (rowv[cc]) n++;
            end
          end
        end
        rowv = cur_grid[r];
        exp_next[r][c] = (n == 3) || (rowv[c] && n == 2);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_bank = 1'b0;
    exp_gen  = 16'd0;
  endtask

  task automatic load_grid();
    for (int r = 0; r < int'(ROWS); r++) begin
      mem[exp_bank][r]  = cur_grid[r];
      mem[!exp_bank][r] = $urandom();
    end
  endtask

  task automatic random_grid();
    for (int r = 0; r < int'(ROWS); r++) cur_grid[r] = $urandom() & $urandom();
  endtask

  // One generation, checked cycle by cycle from cycle 1 to the done cycle, then the IDLE cycle.
  task automatic run_gen(input bit hold);
    bit          nb;
    logic [15:0] ng;
    compute_next();
    nb = !exp_bank;
    ng = exp_gen + 16'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = hold;
    for (int c = 1; c <= DONE_C; c++) begin
      bit er;
      bit ew;
      int ea;
      @(negedge clk);
      er = (c <= NUM_READS);
      ew = (c >= FIRST_WR_C) && (c < FIRST_WR_C + int'(ROWS));
      checks++;
      if (rd_en !== er) begin
        failures++;
        $display("FAIL rd_en cyc=%0d got=%0b exp=%0b", c, rd_en, er);
      end
      if (er) begin
        ea = TORUS ? ((c == 1) ? int'(ROWS) - 1 : (c - 2) % int'(ROWS)) : c - 1;
        checks++;
        if (rd_addr !== ADDR_W'(ea)) begin
          failures++;
          $display("FAIL rd_addr cyc=%0d got=%0d exp=%0d", c, rd_addr, ea);
        end
      end
      checks++;
      if (wr_en !== ew) begin
        failures++;
        $display("FAIL wr_en cyc=%0d got=%0b exp=%0b", c, wr_en, ew);
      end
      if (ew) begin
        ea = c - FIRST_WR_C;
        checks++;
        if (wr_addr !== ADDR_W'(ea) || wr_data !== exp_next[ea]) begin
          failures++;
          $display("FAIL wr cyc=%0d got=%0d/%h exp=%0d/%h", c, wr_addr, wr_data, ea, exp_next[ea]);
        end
      end
      checks++;
      if (busy !== (c < DONE_C) || done !== (c == DONE_C)) begin
        failures++;
        $display("FAIL busy_done cyc=%0d got=%0b%0b exp=%0b%0b", c, busy, done, c < DONE_C, c == DONE_C);
      end
      checks++;
      if (rd_bank !== ((c == DONE_C) ? nb : exp_bank) ||
          gen_count !== ((c == DONE_C) ? ng : exp_gen)) begin
        failures++;
        $display("FAIL bank_gen cyc=%0d got=%0b/%0d", c, rd_bank, gen_count);
      end
    end
    exp_bank = nb;
    exp_gen  = ng;
    for (int r = 0; r < int'(ROWS); r++) begin
      checks++;
      if (mem[exp_bank][r] !== exp_next[r]) begin
        failures++;
        $display("FAIL row%0d got=%h exp=%h", r, mem[exp_bank][r], exp_next[r]);
      end
      cur_grid[r] = exp_next[r];
    end
    @(negedge clk);
    checks++;
    if (rd_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle_after got=%0b%0b%0b exp=000", rd_en, busy, done);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, rd_en, wr_en, rd_bank} !== 5'b0 || gen_count !== 16'd0) begin
        failures++;
        $display("FAIL reset_ctl got=%b gen=%0d", {busy, done, rd_en, wr_en, rd_bank}, gen_count);
      end
      checks++;
      if (rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0 ||
          row_top !== '0 || row_mid !== '0 || row_bot !== '0) begin
        failures++;
        $display("FAIL reset_data got=%0d %0d %h %h %h %h", rd_addr, wr_addr, wr_data, row_top, row_mid, row_bot);
      end
    end
  endtask

  task automatic test_all_zero();
    for (int r = 0; r < int'(ROWS); r++) cur_grid[r] = '0;
    load_grid();
    run_gen(1'b0);
    checks++;
    if (gen_count !== 16'd1 || rd_bank !== 1'b1) begin
      failures++;
      $display("FAIL zero_gen got=%0d/%0b exp=1/1", gen_count, rd_bank);
    end
  endtask

  task automatic test_blinker();
    do_reset();
    for (int r = 0; r < int'(ROWS); r++) cur_grid[r] = '0;
    cur_grid[11] = 32'h0000_0700;
    load_grid();
    run_gen(1'b0);
    for (int r = 10; r <= 12; r++) begin
      checks++;
      if (mem[1][r] !== 32'h0000_0200) begin
        failures++;
        $display("FAIL blinker_v row%0d got=%h exp=00000200", r, mem[1][r]);
      end
    end
    run_gen(1'b0);
    checks++;
    if (mem[0][10] !== 32'h0 || mem[0][11] !== 32'h0000_0700 || mem[0][12] !== 32'h0 ||
        gen_count !== 16'd2) begin
      failures++;
      $display("FAIL blinker_h got=%h %h %h gen=%0d exp=0 700 0 gen=2", mem[0][10], mem[0][11], mem[0][12], gen_count);
    end
  endtask

  task automatic test_random();
    random_grid();
    load_grid();
    for (int g = 0; g < 3; g++) run_gen(1'b0);
  endtask

  task automatic test_start_held();
    random_grid();
    load_grid();
    run_gen(1'b1);
    @(negedge clk);
    checks++;
    if (rd_en !== 1'b1 || busy !== 1'b1 || rd_addr !== ADDR_W'(TORUS ? ROWS - 1 : 0)) begin
      failures++;
      $display("FAIL held_restart got=%0b%0b/%0d exp=11", rd_en, busy, rd_addr);
    end
    start = 1'b0;
    do_reset();
  endtask

  task automatic test_reset_mid();
    do_reset();
    random_grid();
    load_grid();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (rd_en !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0 || rd_bank !== 1'b0 || gen_count !== 16'd0) begin
        failures++;
        $display("FAIL abort cyc=%0d got=%0b%0b%0b%0b gen=%0d", i, rd_en, wr_en, busy, rd_bank, gen_count);
      end
    end
    for (int r = 0; r < int'(ROWS); r++) begin
      checks++;
      if (mem[0][r] !== cur_grid[r]) begin
        failures++;
        $display("FAIL abort_bank0 row%0d got=%h exp=%h", r, mem[0][r], cur_grid[r]);
      end
    end
    exp_bank = 1'b0;
    exp_gen  = 16'd0;
    run_gen(1'b0);
  endtask

`ifdef GOL_TORUS_WRAP_EN
  task automatic test_torus();
    do_reset();
    for (int r = 0; r < int'(ROWS); r++) cur_grid[r] = '0;
    cur_grid[ROWS-1] = 32'h1;
    cur_grid[0]      = 32'h1;
    cur_grid[1]      = 32'h1;
    load_grid();
    run_gen(1'b0);
    checks++;
    if (mem[1][ROWS-1] !== 32'h0 || mem[1][0] !== 32'h3 || mem[1][1] !== 32'h0) begin
      failures++;
      $display("FAIL torus got=%h %h %h exp=0 3 0", mem[1][ROWS-1], mem[1][0], mem[1][1]);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    test_reset();
    test_all_zero();
    test_blinker();
    test_random();
    test_start_held();
    test_reset_mid();
`ifdef GOL_TORUS_WRAP_EN
    test_torus();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
